// File: rtl/rom_bram_arb_pkg.sv
// Shared types for the ROM BRAM port arbiter.
//   owner_e     : which requester a grant / read tag belongs to
//   arb_state_e : arbiter FSM states
//   rd_tag_t    : one read-tag pipe entry {vld, owner}
//   RD_LAT_MAX  : deepest supported BRAM read latency
package rom_bram_arb_pkg;

    localparam int RD_LAT_MAX = 4;

    typedef enum logic {
        OWN_REQ0 = 1'b0,
        OWN_REQ1 = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic   vld;
        owner_e owner;
    } rd_tag_t;

endpackage

// File: rtl/rom_bram_rd_tag_pipe.sv
// Read-tag delay line. It matches the BRAM read latency so that the head entry
// lines up with the cycle in which bram_rdata carries the data for that read.
//   clk      : clock
//   clr      : synchronous clear; drops every in-flight tag
//   tag_in   : tag for the access granted this cycle
//   tag_head : tag whose data is on bram_rdata this cycle
//   any_vld  : some read is still in flight
module rom_bram_rd_tag_pipe
    import rom_bram_arb_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic    clk,
    input  logic    clr,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_head,
    output logic    any_vld
);

    rd_tag_t stage [RD_LAT];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < RD_LAT; i++) stage[i] <= '{vld: 1'b0, owner: OWN_REQ0};
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < RD_LAT; i++) stage[i] <= stage[i-1];
        end
    end

    assign tag_head = stage[RD_LAT-1];

    always_comb begin
        any_vld = 1'b0;
        for (int i = 0; i < RD_LAT; i++) any_vld = any_vld | stage[i].vld;
    end

endmodule

// File: rtl/rom_bram_port_arbiter.sv
// Shares the single ROM BRAM native port between requester 0 (SoC AXI BRAM
// loader) and requester 1 (debug / readback checker). Round-robin with a
// bounded burst hold; zero-wait grant; read data steered back by a tag pipe.
//
// Ports:
//   core_clk, core_rst         : clock, synchronous active-high reset
//   reqN_valid/we/addr/wdata   : request N (we == 0 means read)
//   reqN_gnt                   : request N accepted this cycle
//   reqN_rvalid/rdata          : read return for requester N
//   bram_en/we/addr/wdata      : BRAM native port drive
//   bram_rdata                 : BRAM read data, RD_LAT cycles after enable
//   busy                       : read in flight or request pending
//
// Optional macro ROM_BRAM_ARB_WR_LOCK_EN adds:
//   rom_wr_lock                : drop writes (still granted) while set
//   wr_lock_err                : one-cycle pulse, the cycle after a dropped write
module rom_bram_port_arbiter
    import rom_bram_arb_pkg::*;
#(
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 32,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 16
) (
    input  logic                core_clk,
    input  logic                core_rst,
    input  logic                req0_valid,
    input  logic [DATA_W/8-1:0] req0_we,
    input  logic [ADDR_W-1:0]   req0_addr,
    input  logic [DATA_W-1:0]   req0_wdata,
    output logic                req0_gnt,
    output logic                req0_rvalid,
    output logic [DATA_W-1:0]   req0_rdata,
    input  logic                req1_valid,
    input  logic [DATA_W/8-1:0] req1_we,
    input  logic [ADDR_W-1:0]   req1_addr,
    input  logic [DATA_W-1:0]   req1_wdata,
    output logic                req1_gnt,
    output logic                req1_rvalid,
    output logic [DATA_W-1:0]   req1_rdata,
    output logic                bram_en,
    output logic [DATA_W/8-1:0] bram_we,
    output logic [ADDR_W-1:0]   bram_addr,
    output logic [DATA_W-1:0]   bram_wdata,
    input  logic [DATA_W-1:0]   bram_rdata,
`ifdef ROM_BRAM_ARB_WR_LOCK_EN
    input  logic                rom_wr_lock,
    output logic                wr_lock_err,
`endif
    output logic                busy
);

    localparam int STRB_W = DATA_W / 8;
    // Out-of-range latencies are clamped to the supported 1..RD_LAT_MAX.
    localparam int LAT    = (RD_LAT < 1) ? 1 : ((RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT);
    localparam int CNT_W  = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    arb_state_e        state, state_nxt;
    owner_e            ptr;
    logic [CNT_W-1:0]  cnt;

    logic              any_gnt, is_wr, lock_drop;
    logic [STRB_W-1:0] sel_we;
    logic [ADDR_W-1:0] sel_addr, addr_q;
    logic [DATA_W-1:0] sel_wdata, wdata_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;
    rd_tag_t           tag_in, tag_head;
    logic              tag_any;

    // ------------------------------------------------------------------
    // Arbiter FSM. The grant follows the next state, so the owner entered
    // this cycle is granted in the same cycle (zero-wait). Every OWNx state
    // is only entered or kept while reqx_valid is high.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: begin
                if (req0_valid && (ptr == OWN_REQ0 || !req1_valid)) state_nxt = ARB_OWN0;
                else if (req1_valid)                                state_nxt = ARB_OWN1;
            end
            ARB_OWN0: begin
                if (req0_valid && !(req1_valid && cnt == CNT_LAST)) state_nxt = ARB_OWN0;
                else if (req1_valid)                                state_nxt = ARB_OWN1;
                else                                                state_nxt = ARB_IDLE;
            end
            ARB_OWN1: begin
                if (req1_valid && !(req0_valid && cnt == CNT_LAST)) state_nxt = ARB_OWN1;
                else if (req0_valid)                                state_nxt = ARB_OWN0;
                else                                                state_nxt = ARB_IDLE;
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            state <= ARB_IDLE;
            ptr   <= OWN_REQ0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            // cnt = grants to the current owner minus one; 0 on the first grant.
            if (state_nxt != state)                       cnt <= '0;
            else if (state != ARB_IDLE && cnt != CNT_LAST) cnt <= cnt + 1'b1;
            if (state == ARB_OWN0 && state_nxt != ARB_OWN0) ptr <= OWN_REQ1;
            if (state == ARB_OWN1 && state_nxt != ARB_OWN1) ptr <= OWN_REQ0;
        end
    end

    // Grants are masked during reset so every output reads 0 while it is held.
    assign req0_gnt = !core_rst && (state_nxt == ARB_OWN0);
    assign req1_gnt = !core_rst && (state_nxt == ARB_OWN1);
    assign any_gnt  = req0_gnt | req1_gnt;

    // ------------------------------------------------------------------
    // BRAM port drive
    // ------------------------------------------------------------------
    assign sel_we    = req1_gnt ? req1_we    : req0_we;
    assign sel_addr  = req1_gnt ? req1_addr  : req0_addr;
    assign sel_wdata = req1_gnt ? req1_wdata : req0_wdata;
    assign is_wr     = |sel_we;

`ifdef ROM_BRAM_ARB_WR_LOCK_EN
    // A locked write is still granted (the requester moves on) but never
    // reaches the BRAM.
    assign lock_drop = rom_wr_lock & is_wr;

    always_ff @(posedge core_clk) begin
        if (core_rst) wr_lock_err <= 1'b0;
        else          wr_lock_err <= any_gnt & lock_drop;
    end
`else
    assign lock_drop = 1'b0;
`endif

    assign bram_en    = any_gnt & ~lock_drop;
    assign bram_we    = bram_en ? sel_we    : '0;
    assign bram_addr  = bram_en ? sel_addr  : addr_q;
    assign bram_wdata = bram_en ? sel_wdata : wdata_q;

    // Address / data hold their last driven value between accesses.
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (bram_en) begin
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Read return
    // ------------------------------------------------------------------
    assign tag_in.vld   = any_gnt & ~is_wr;
    assign tag_in.owner = req1_gnt ? OWN_REQ1 : OWN_REQ0;

    rom_bram_rd_tag_pipe #(.RD_LAT(LAT)) u_tag_pipe (
        .clk      (core_clk),
        .clr      (core_rst),
        .tag_in   (tag_in),
        .tag_head (tag_head),
        .any_vld  (tag_any)
    );

    assign req0_rvalid = !core_rst && tag_head.vld && tag_head.owner == OWN_REQ0;
    assign req1_rvalid = !core_rst && tag_head.vld && tag_head.owner == OWN_REQ1;

    // bram_rdata passes straight through in the return cycle; the hold
    // register keeps it afterwards so the idle side never glitches.
    assign req0_rdata = req0_rvalid ? bram_rdata : rdata0_q;
    assign req1_rdata = req1_rvalid ? bram_rdata : rdata1_q;

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (req0_rvalid) rdata0_q <= bram_rdata;
            if (req1_rvalid) rdata1_q <= bram_rdata;
        end
    end

    assign busy = !core_rst && (tag_any | req0_valid | req1_valid);

endmodule
